// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit core: drives the PC, instruction fetch and ALU strobes.
// Optional build macro ILLEGAL_TRAP_EN turns illegal opcodes into a one-cycle trap jump to TRAP_VECTOR.
module pc_sequencer #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR = 8'hF0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr_data,
  input  logic              mem_ack,
  input  logic              zero_flag,
  output logic              mem_req,
  output logic              LoadPC,
  output logic              IncPC,
  output logic [ADDR_W-1:0] new_count,
  output logic [3:0]        alu_op,
  output logic              alu_en,
  output logic              acc_we,
  output logic [DATA_W-1:0] ir,
  output logic              halted,
  output logic              trap
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_OPERAND, S_BRANCH, S_HALT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] target;
  logic              trap_pend;
  logic [3:0]        opc;
  logic              is_alu, is_jmp, is_jz, is_halt, is_nop;

  assign opc     = ir[7:4];
  assign is_alu  = (opc == 4'h1) || (opc == 4'h2) || (opc == 4'h3) || (opc == 4'hB) || (opc == 4'hC);
  assign is_jmp  = (opc == 4'h8);
  assign is_jz   = (opc == 4'h9);
  assign is_halt = (opc == 4'hF);
  assign is_nop  = (opc == 4'h0);

  // mem_req is registered, so IncPC can only fire in a FETCH/OPERAND cycle
  assign IncPC     = mem_req & mem_ack;
  assign LoadPC    = (state == S_BRANCH) & (trap_pend | is_jmp | (is_jz & zero_flag));
  assign new_count = target;
  assign alu_op    = opc;

`ifdef ILLEGAL_TRAP_EN
  assign trap = (state == S_BRANCH) & trap_pend;
`else
  logic unused_trap_vector;
  assign unused_trap_vector = ^TRAP_VECTOR;
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_FETCH;
      ir        <= '0;
      target    <= '0;
      trap_pend <= 1'b0;
      mem_req   <= 1'b0;
      alu_en    <= 1'b0;
      acc_we    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      alu_en <= 1'b0;
      acc_we <= 1'b0;
      case (state)
        S_FETCH: begin
          mem_req <= 1'b1;
          if (mem_ack && mem_req) begin
            ir      <= instr_data;
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_alu) begin
            alu_en <= 1'b1;
            acc_we <= 1'b1;
            state  <= S_EXEC;
          end else if (is_jmp || is_jz) begin
            mem_req <= 1'b1;
            state   <= S_OPERAND;
          end else if (is_halt) begin
            halted <= 1'b1;
            state  <= S_HALT;
`ifdef ILLEGAL_TRAP_EN
          end else if (!is_nop) begin
            target    <= TRAP_VECTOR;
            trap_pend <= 1'b1;
            state     <= S_BRANCH;
`endif
          end else begin
            mem_req <= 1'b1;
            state   <= S_FETCH;
          end
        end
        S_EXEC: begin
          mem_req <= 1'b1;
          state   <= S_FETCH;
        end
        S_OPERAND: begin
          if (mem_ack) begin
            target  <= instr_data[ADDR_W-1:0];
            mem_req <= 1'b0;
            state   <= S_BRANCH;
          end
        end
        S_BRANCH: begin
          trap_pend <= 1'b0;
          mem_req   <= 1'b1;
          state     <= S_FETCH;
        end
        S_HALT: begin
          mem_req <= 1'b0;
        end
        default: begin
          mem_req <= 1'b0;
          state   <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: an instruction-level model predicts each PC/ALU event and its cycle,
// a negedge monitor pops and compares whenever the DUT shows an event.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] instr_data;
  logic       mem_ack = 1'b0;
  logic       zero_flag = 1'b0;
  logic       mem_req, LoadPC, IncPC, alu_en, acc_we, halted, trap;
  logic [7:0] new_count, ir;
  logic [3:0] alu_op;

  pc_sequencer #(.ADDR_W(8), .DATA_W(8), .TRAP_VECTOR(8'hF0)) dut (
    .clk(clk), .reset(reset), .instr_data(instr_data), .mem_ack(mem_ack), .zero_flag(zero_flag),
    .mem_req(mem_req), .LoadPC(LoadPC), .IncPC(IncPC), .new_count(new_count), .alu_op(alu_op),
    .alu_en(alu_en), .acc_we(acc_we), .ir(ir), .halted(halted), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; int val; int cyc;} ev_t;
  localparam int K_INC = 0, K_ALU = 1, K_LOAD = 2, K_HALT = 3;

  ev_t        expq[$];
  logic [7:0] mem[256];
  int         delays[64];
  logic [7:0] pc_env;
  int         cyc;
  int         errors = 0, checks = 0;
  int         acc_idx = 0, wait_cnt = 0;
  bit         prev_halted = 0;

  // environment: program counter and instruction memory the sequencer controls
  assign instr_data = mem[pc_env];
  always @(posedge clk) begin
    if (!reset) begin
      pc_env <= 8'h00;
      cyc    <= 0;
    end else begin
      cyc <= cyc + 1;
      if (LoadPC) pc_env <= new_count;
      else if (IncPC) pc_env <= pc_env + 8'h01;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int val, input int c);
    ev_t e;
    e.kind = kind; e.val = val; e.cyc = c;
    expq.push_back(e);
  endtask

  task automatic monitor_cycle();
    ev_t e;
    bit  seen = 1;
    int  kind = 0, val = 0;
    check("inc_load_exclusive", {31'd0, IncPC & LoadPC}, 0);
    if (!LoadPC) check("trap_idle", {31'd0, trap}, 0);
    if (IncPC) begin kind = K_INC; val = 0; end
    else if (LoadPC) begin kind = K_LOAD; val = {23'd0, trap, new_count}; end
    else if (alu_en || acc_we) begin kind = K_ALU; val = {26'd0, alu_en, acc_we, alu_op}; end
    else if (halted && !prev_halted) begin kind = K_HALT; val = {30'd0, halted, mem_req}; end
    else seen = 0;
    prev_halted = halted;
    if (seen) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event: got kind %0d val %0h at cycle %0d, expected none", kind, val, cyc);
      end else begin
        e = expq.pop_front();
        check("event_kind", kind, e.kind);
        check("event_val", val, e.val);
        check("event_cycle", cyc, e.cyc);
      end
    end
  endtask

  // memory responder plus monitor, both just after the falling edge
  always begin
    @(negedge clk);
    if (!reset) mem_ack = 1'b1;
    else if (mem_req) begin
      if (wait_cnt >= delays[acc_idx % 64]) begin
        mem_ack = 1'b1; acc_idx++; wait_cnt = 0;
      end else begin
        mem_ack = 1'b0; wait_cnt++;
      end
    end else mem_ack = 1'($urandom_range(0, 1));
    #1;
    if (reset) monitor_cycle();
  end

  // instruction-level reference: walks the program and predicts event timing from the opcode latencies
  task automatic gen_expected(input bit z, input int maxi, output bit halts);
    int         t = 1, a = 0, tf, ta;
    logic [7:0] pc = 8'h00, tgt;
    logic [3:0] op;
    halts = 0;
    for (int i = 0; i < maxi && !halts; i++) begin
      op = mem[pc][7:4];
      tf = t + delays[a % 64]; a++;
      push(K_INC, 0, tf);
      pc = pc + 8'h01;
      case (op)
        4'h1, 4'h2, 4'h3, 4'hB, 4'hC: begin push(K_ALU, 32'h30 | op, tf + 2); t = tf + 3; end
        4'h8, 4'h9: begin
          ta = tf + 2 + delays[a % 64]; a++;
          push(K_INC, 0, ta);
          tgt = mem[pc];
          pc = pc + 8'h01;
          if (op == 4'h8 || z) begin push(K_LOAD, tgt, ta + 1); pc = tgt; end
          t = ta + 2;
        end
        4'hF: begin push(K_HALT, 2, tf + 2); halts = 1; end
        4'h0: t = tf + 2;
        default: begin
`ifdef ILLEGAL_TRAP_EN
          push(K_LOAD, 32'h1F0, tf + 2); pc = 8'hF0; t = tf + 3;
`else
          t = tf + 2;
`endif
        end
      endcase
    end
  endtask

  task automatic start_run(input bit z);
    zero_flag = z;
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk); #2;
      check("reset_outputs", {mem_req, LoadPC, IncPC, alu_en, acc_we, halted, trap, new_count, alu_op, ir}, 0);
    end
    acc_idx = 0; wait_cnt = 0; prev_halted = 0;
    expq.delete();
  endtask

  task automatic release_run();
    reset = 1'b1;
    @(negedge clk); #2;
    check("mem_req_after_release", {31'd0, mem_req}, 1);
    check("ir_after_release", {24'd0, ir}, 0);
  endtask

  task automatic drain(input bit halts);
    int n = 0;
    while (expq.size() > 0 && n < 3000) begin @(negedge clk); #2; n++; end
    if (expq.size() > 0) begin
      check("drain_timeout_pending", expq.size(), 0);
      expq.delete();
    end
    if (halts) repeat (10) begin
      @(negedge clk); #2;
      check("halt_hold", {30'd0, halted, mem_req}, 2);
    end
  endtask

  task automatic directed_prog();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 64; i++) delays[i] = 0;
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h20; mem[8'h02] = 8'h80; mem[8'h03] = 8'h11;
    mem[8'h11] = 8'h90; mem[8'h12] = 8'h22; mem[8'h13] = 8'h50; mem[8'h14] = 8'hF0;
    mem[8'h22] = 8'hF0; mem[8'hF0] = 8'hF0;
    delays[1] = 3;
  endtask

  initial begin
    int  op_tbl[20] = '{0, 1, 1, 2, 2, 3, 3, 11, 11, 12, 12, 8, 8, 9, 9, 9, 4, 5, 14, 15};
    bit  h, z;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 64; i++) delays[i] = 0;

    // directed program: ADD, SUB with late ack, JMP, JZ, illegal, HALT, both zero_flag values
    for (int k = 0; k < 2; k++) begin
      directed_prog();
      start_run(k[0]);
      gen_expected(k[0], 20, h);
      release_run();
      drain(h);
    end

    // reset during an operand wait: no branch, outputs clear, fetch restarts
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h80;
    for (int i = 0; i < 64; i++) delays[i] = 0;
    delays[1] = 60;
    start_run(1'b0);
    push(K_INC, 0, 1);
    release_run();
    drain(1'b0);
    repeat (3) begin @(negedge clk); #2; end
    check("operand_wait_req", {31'd0, mem_req}, 1);
    reset = 1'b0;
    @(negedge clk); #2;
    check("midop_reset_outputs", {mem_req, LoadPC, IncPC, alu_en, acc_we, halted, trap, new_count, alu_op, ir}, 0);
    acc_idx = 0; wait_cnt = 0;
    delays[1] = 0;
    push(K_INC, 0, 1);
    release_run();
    drain(1'b0);

    // random programs with random ack stretching
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 256; i++)
        mem[i] = {4'(op_tbl[$urandom_range(0, 19)]), 4'($urandom_range(0, 15))};
      for (int i = 0; i < 64; i++)
        delays[i] = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
      z = 1'($urandom_range(0, 1));
      start_run(z);
      gen_expected(z, 30, h);
      release_run();
      drain(h);
    end

    reset = 1'b0;
    @(negedge clk); #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule
